// File: rtl/seq_mag_comparator.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared CHUNK
// bits per clock, most significant chunk first. Signed (two's complement) and
// unsigned compares are selectable per operation. With EARLY_EXIT=1 the compare
// stops on the first differing chunk. With EARLY_EXIT=0 it always takes
// WIDTH/CHUNK cycles. WIDTH must be a multiple of CHUNK.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a compare, sampled only while busy=0
//   signed_mode  1 = two's complement compare, sampled with start
//   x, y         operands, sampled with start
//   busy         compare in progress
//   done         one-cycle pulse on the edge the result flags update
//   ceq/clt/cgt  x==y / x<y / x>y, registered and held between operations
//   cycles       chunk-compare cycles used by the last operation, held
// -----------------------------------------------------------------------------
module seq_mag_comparator #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHUNK      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     x,
    input  logic [WIDTH-1:0]                     y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 ceq,
    output logic                                 clt,
    output logic                                 cgt,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]     cycles
);

    localparam int unsigned NChunk = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam int unsigned CntW   = $clog2(NChunk + 1);
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NChunk - 1);

    typedef enum logic [0:0] {StIdle, StCmp} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              sgn_q, sgn_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    // decided_q: a higher chunk already differed; lt_q/gt_q hold that verdict
    logic              decided_q, decided_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ceq_q, ceq_d;
    logic              clt_q, clt_d;
    logic              cgt_q, cgt_d;
    logic [CntW-1:0]   cycles_q, cycles_d;

    logic [WIDTH-1:0]  x_shift, y_shift;
    logic [CHUNK-1:0]  x_chunk, y_chunk;
    logic              differs;
    logic              lt_now, gt_now;
    logic              finish;

    // Chunk select; in signed mode the sign bit of the top chunk is inverted so
    // that an unsigned compare of that chunk orders negative below positive.
    always_comb begin
        x_shift = x_q >> (idx_q * CHUNK);
        y_shift = y_q >> (idx_q * CHUNK);
        x_chunk = x_shift[CHUNK-1:0];
        y_chunk = y_shift[CHUNK-1:0];
        if (sgn_q && (idx_q == IdxTop)) begin
            x_chunk[CHUNK-1] = ~x_chunk[CHUNK-1];
            y_chunk[CHUNK-1] = ~y_chunk[CHUNK-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        sgn_d     = sgn_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ceq_d     = ceq_q;
        clt_d     = clt_q;
        cgt_d     = cgt_q;
        cycles_d  = cycles_q;

        differs = (x_chunk != y_chunk);
        // A verdict from a higher chunk is never overwritten by lower chunks.
        lt_now  = decided_q ? lt_q : (x_chunk < y_chunk);
        gt_now  = decided_q ? gt_q : (x_chunk > y_chunk);
        finish  = (differs && (EARLY_EXIT != 0)) || (idx_q == '0);

        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d       = x;
                    y_d       = y;
                    sgn_d     = signed_mode;
                    idx_d     = IdxTop;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    gt_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StCmp;
                end
            end
            StCmp: begin
                if (finish) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    ceq_d    = ~lt_now & ~gt_now;
                    clt_d    = lt_now;
                    cgt_d    = gt_now;
                    // Chunks consumed so far, including this one.
                    cycles_d = CntW'(NChunk - 32'(idx_q));
                end else begin
                    idx_d     = idx_q - 1'b1;
                    lt_d      = lt_now;
                    gt_d      = gt_now;
                    decided_d = decided_q | differs;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            sgn_q     <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ceq_q     <= 1'b0;
            clt_q     <= 1'b0;
            cgt_q     <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sgn_q     <= sgn_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ceq_q     <= ceq_d;
            clt_q     <= clt_d;
            cgt_q     <= cgt_d;
            cycles_q  <= cycles_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ceq    = ceq_q;
    assign clt    = clt_q;
    assign cgt    = cgt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: an EARLY_EXIT=1 instance and an
// EARLY_EXIT=0 instance share clock, reset and operands but have separate starts.
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_ne;
    logic        signed_mode;
    logic [15:0] xa, yb;
    logic        busy, done, ceq, clt, cgt;
    logic [2:0]  cycles;
    logic        busy_ne, done_ne, ceq_ne, clt_ne, cgt_ne;
    logic [2:0]  cycles_ne;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .x(xa), .y(yb), .busy(busy), .done(done), .ceq(ceq), .clt(clt), .cgt(cgt),
        .cycles(cycles)
    );

    seq_mag_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u_dut_ne (
        .clk(clk), .rst_n(rst_n), .start(start_ne), .signed_mode(signed_mode),
        .x(xa), .y(yb), .busy(busy_ne), .done(done_ne), .ceq(ceq_ne), .clt(clt_ne),
        .cgt(cgt_ne), .cycles(cycles_ne)
    );

    // Pulse start on the selected instance and return the number of edges after
    // the start-sampling edge until done is seen (-1 if it never arrives).
    // Returns at the falling edge where done is high.
    task automatic do_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output int lat);
        xa = a; yb = b; signed_mode = s;
        if (sel) start_ne = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_ne = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel ? done_ne : done) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; start_ne = 1'b1; signed_mode = 1'b0;
        xa = 16'h0001; yb = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, ceq, clt, cgt, cycles} !== 8'h00) begin
                failures++;
                $display("FAIL reset_state got %b want 00000000",
                         {busy, done, ceq, clt, cgt, cycles});
            end
        end
        start = 1'b0; start_ne = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, busy_ne} !== 2'b00) begin
            failures++;
            $display("FAIL reset_start_ignored got busy=%b%b want 00", busy, busy_ne);
        end
    endtask

    task automatic test_first_chunk();
        xa = 16'h0000; yb = 16'hD000; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL first_busy got busy=%b done=%b want 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, ceq, clt, cgt, cycles} !== 8'b01_010_001) begin
            failures++;
            $display("FAIL first_result got %b want 01010001",
                     {busy, done, ceq, clt, cgt, cycles});
        end
        @(negedge clk);
        checks++;
        if ({done, ceq, clt, cgt, cycles} !== 7'b0_010_001) begin
            failures++;
            $display("FAIL first_hold got %b want 0010001", {done, ceq, clt, cgt, cycles});
        end
    endtask

    task automatic test_equal();
        int lat;
        do_op(1'b0, 16'h1234, 16'h1234, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL equal_latency got %0d want 4", lat);
        end
        checks++;
        if ({busy, ceq, clt, cgt, cycles} !== 7'b0_100_100) begin
            failures++;
            $display("FAIL equal_result got %b want 0100100", {busy, ceq, clt, cgt, cycles});
        end
    endtask

    task automatic test_signed();
        int lat;
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b1, lat);
        checks++;
        if ({lat == 1, ceq, clt, cgt, cycles} !== 7'b1_010_001) begin
            failures++;
            $display("FAIL signed_neg1_vs_1 got lat=%0d flags=%b cycles=%0d want 1 010 1",
                     lat, {ceq, clt, cgt}, cycles);
        end
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat);
        checks++;
        if ({lat == 1, ceq, clt, cgt, cycles} !== 7'b1_001_001) begin
            failures++;
            $display("FAIL unsigned_ffff_vs_1 got lat=%0d flags=%b cycles=%0d want 1 001 1",
                     lat, {ceq, clt, cgt}, cycles);
        end
        do_op(1'b0, 16'h8000, 16'h7FFF, 1'b1, lat);
        checks++;
        if ({ceq, clt, cgt, cycles} !== 6'b010_001) begin
            failures++;
            $display("FAIL signed_min_vs_max got flags=%b cycles=%0d want 010 1",
                     {ceq, clt, cgt}, cycles);
        end
        // -2 < -1: top chunks equal after sign flip, decided in the last chunk
        do_op(1'b0, 16'hFFFE, 16'hFFFF, 1'b1, lat);
        checks++;
        if ({lat == 4, ceq, clt, cgt, cycles} !== 7'b1_010_100) begin
            failures++;
            $display("FAIL signed_m2_vs_m1 got lat=%0d flags=%b cycles=%0d want 4 010 4",
                     lat, {ceq, clt, cgt}, cycles);
        end
    endtask

    task automatic test_mid_chunk();
        int lat;
        // Nibbles 1,2,A,4 vs 1,2,9,4: first difference is the third chunk.
        do_op(1'b0, 16'h12A4, 16'h1294, 1'b0, lat);
        checks++;
        if ({lat == 3, ceq, clt, cgt, cycles} !== 7'b1_001_011) begin
            failures++;
            $display("FAIL mid_early got lat=%0d flags=%b cycles=%0d want 3 001 3",
                     lat, {ceq, clt, cgt}, cycles);
        end
        do_op(1'b1, 16'h12A4, 16'h1294, 1'b0, lat);
        checks++;
        if ({lat == 4, ceq_ne, clt_ne, cgt_ne, cycles_ne} !== 7'b1_001_100) begin
            failures++;
            $display("FAIL mid_const got lat=%0d flags=%b cycles=%0d want 4 001 4",
                     lat, {ceq_ne, clt_ne, cgt_ne}, cycles_ne);
        end
        // Lower chunks point the other way; top-chunk verdict must stand.
        do_op(1'b1, 16'h2000, 16'h1FFF, 1'b0, lat);
        checks++;
        if ({lat == 4, ceq_ne, clt_ne, cgt_ne, cycles_ne} !== 7'b1_001_100) begin
            failures++;
            $display("FAIL no_overwrite got lat=%0d flags=%b cycles=%0d want 4 001 4",
                     lat, {ceq_ne, clt_ne, cgt_ne}, cycles_ne);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        xa = 16'h1234; yb = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        // Busy now: corrupt operand and re-request; both must be ignored.
        xa = 16'hFFFF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) pulses++;
            if (i < 4) begin
                checks++;
                if ({busy, done} !== 2'b10) begin
                    failures++;
                    $display("FAIL isolate_busy_%0d got busy=%b done=%b want 1 0",
                             i, busy, done);
                end
            end
        end
        checks++;
        if ({pulses == 1, busy, ceq, clt, cgt, cycles} !== 8'b1_0_100_100) begin
            failures++;
            $display("FAIL isolate_result got pulses=%0d busy=%b flags=%b cycles=%0d want 1 0 100 4",
                     pulses, busy, {ceq, clt, cgt}, cycles);
        end
        // Start in the done cycle is accepted.
        xa = 16'h0001; yb = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, ceq, clt, cgt} !== 5'b10_100) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b done=%b flags=%b want 1 0 100",
                     busy, done, {ceq, clt, cgt});
        end
        pulses = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses = i;
                break;
            end
        end
        checks++;
        if ({pulses == 4, ceq, clt, cgt, cycles} !== 7'b1_010_100) begin
            failures++;
            $display("FAIL b2b_result got lat=%0d flags=%b cycles=%0d want 4 010 4",
                     pulses, {ceq, clt, cgt}, cycles);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        xa = 16'h5555; yb = 16'h5555; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Low at the second compare edge, with start held high.
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, ceq, clt, cgt, cycles} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_state got %b want 00000000",
                     {busy, done, ceq, clt, cgt, cycles});
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if ({seen == 0, ceq, clt, cgt, cycles} !== 7'b1_000_000) begin
            failures++;
            $display("FAIL reset_mid_quiet got activity=%0d flags=%b cycles=%0d want 0 000 0",
                     seen, {ceq, clt, cgt}, cycles);
        end
    endtask

    // done and busy are never high together.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1 && busy === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_with_busy got done=1 busy=1 want not both");
        end
    end

    initial begin
        test_reset();
        test_first_chunk();
        test_equal();
        test_signed();
        test_mid_chunk();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
